// File: rtl/game_status.sv
// rtl/game_status.sv - player lives, enemy count, key and hit-cooldown tracker for the game state machine
module game_status #(
  parameter int LIVES_INIT    = 3,
  parameter int EN_FIRST      = 3,
  parameter int EN_SECOND     = 4,
  parameter int EN_THIRD      = 5,
  parameter int EN_FINAL      = 1,
  parameter int INVULN_CYCLES = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] level,
  input  logic       player_hit,
  input  logic       enemy_kill,
  input  logic       key_pickup,
  output logic       Lives,
  output logic       Enemies,
  output logic       Keys,
  output logic [2:0] lives_count,
  output logic [3:0] enemy_count,
  output logic       invuln
);

  // One-hot codes of the game state machine: {q_Win, q_Final, q_Third, q_Second, q_First, q_I}
  localparam logic [5:0] LVL_INI    = 6'b000001;
  localparam logic [5:0] LVL_FIRST  = 6'b000010;
  localparam logic [5:0] LVL_SECOND = 6'b000100;
  localparam logic [5:0] LVL_THIRD  = 6'b001000;
  localparam logic [5:0] LVL_FINAL  = 6'b010000;

  logic       key_flag;
  logic [7:0] inv_cnt;
  logic [5:0] level_prev;

  logic       is_ini;
  logic       is_first;
  logic       is_second;
  logic       is_third;
  logic       is_final;
  logic       is_play;
  logic       entry;

  logic [2:0] lives_nxt;
  logic [3:0] enemy_nxt;
  logic       key_nxt;
  logic [7:0] inv_nxt;

  // Decode the level vector; WIN and non-one-hot codes fall through as "no play level"
  always_comb begin
    is_ini    = (level == LVL_INI);
    is_first  = (level == LVL_FIRST);
    is_second = (level == LVL_SECOND);
    is_third  = (level == LVL_THIRD);
    is_final  = (level == LVL_FINAL);
    is_play   = is_first | is_second | is_third | is_final;
    entry     = (level != level_prev);
  end

  // Next-state rules: INI reloads everything, play levels take events, other codes only run the timer
  always_comb begin
    lives_nxt = lives_count;
    enemy_nxt = enemy_count;
    key_nxt   = key_flag;
    inv_nxt   = (inv_cnt != 8'd0) ? inv_cnt - 8'd1 : 8'd0;

    if (is_ini) begin
      lives_nxt = 3'(LIVES_INIT);
      enemy_nxt = 4'd0;
      key_nxt   = 1'b0;
      inv_nxt   = 8'd0;
    end else if (is_play) begin
      // The level load wins over a kill arriving in the same cycle
      if (entry) begin
        if (is_first)       enemy_nxt = 4'(EN_FIRST);
        else if (is_second) enemy_nxt = 4'(EN_SECOND);
        else if (is_third)  enemy_nxt = 4'(EN_THIRD);
        else                enemy_nxt = 4'(EN_FINAL);
      end else if (enemy_kill && (enemy_count != 4'd0)) begin
        enemy_nxt = enemy_count - 4'd1;
      end

      if (player_hit && (inv_cnt == 8'd0) && (lives_count != 3'd0)) begin
        lives_nxt = lives_count - 3'd1;
        inv_nxt   = 8'(INVULN_CYCLES);
      end

      if (key_pickup && is_third) begin
        key_nxt = 1'b1;
      end
    end
  end

  // Status registers with asynchronous reset
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lives_count <= 3'(LIVES_INIT);
      enemy_count <= 4'd0;
      key_flag    <= 1'b0;
      inv_cnt     <= 8'd0;
      level_prev  <= LVL_INI;
    end else begin
      lives_count <= lives_nxt;
      enemy_count <= enemy_nxt;
      key_flag    <= key_nxt;
      inv_cnt     <= inv_nxt;
      level_prev  <= level;
    end
  end

  // Entry override keeps the state machine from seeing the previous level's zero count
  assign Enemies = (enemy_count != 4'd0) | (entry & is_play);
  assign Lives   = (lives_count != 3'd0);
  assign Keys    = key_flag;
  assign invuln  = (inv_cnt != 8'd0);

endmodule

// File: tb/tb_game_status.sv
// tb/tb_game_status.sv - randomized and directed bench for game_status against a behavioural model
module tb_game_status;

  localparam int LIVES_INIT = 3;
  localparam int INV_CYC    = 4;

  localparam logic [5:0] L_INI = 6'b000001;
  localparam logic [5:0] L_F1  = 6'b000010;
  localparam logic [5:0] L_F2  = 6'b000100;
  localparam logic [5:0] L_F3  = 6'b001000;
  localparam logic [5:0] L_FN  = 6'b010000;
  localparam logic [5:0] L_WIN = 6'b100000;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [5:0] level;
  logic       player_hit;
  logic       enemy_kill;
  logic       key_pickup;
  logic       Lives;
  logic       Enemies;
  logic       Keys;
  logic [2:0] lives_count;
  logic [3:0] enemy_count;
  logic       invuln;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  int         m_lives;
  int         m_enemies;
  int         m_key;
  int         m_inv;
  logic [5:0] m_prev;
  int         en_tab[6] = '{0, 3, 4, 5, 1, 0};

  game_status dut (
    .Clk(Clk), .Reset(Reset), .level(level),
    .player_hit(player_hit), .enemy_kill(enemy_kill), .key_pickup(key_pickup),
    .Lives(Lives), .Enemies(Enemies), .Keys(Keys),
    .lives_count(lives_count), .enemy_count(enemy_count), .invuln(invuln)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Index of the one-hot level, -1 when the code is not one-hot
  function automatic int lvl_idx(input logic [5:0] l);
    for (int i = 0; i < 6; i++)
      if (l == (6'b000001 << i)) return i;
    return -1;
  endfunction

  function automatic bit is_play(input logic [5:0] l);
    int i;
    i = lvl_idx(l);
    return (i >= 1 && i <= 4);
  endfunction

  task automatic model_reset();
    m_lives   = LIVES_INIT;
    m_enemies = 0;
    m_key     = 0;
    m_inv     = 0;
    m_prev    = L_INI;
  endtask

  function automatic int model_enemies_out();
    return ((m_enemies > 0) || ((level != m_prev) && is_play(level))) ? 1 : 0;
  endfunction

  task automatic model_step();
    int idx;
    int inv_next;
    idx = lvl_idx(level);
    if (idx == 0) begin
      m_lives = LIVES_INIT; m_enemies = 0; m_key = 0; m_inv = 0;
    end else begin
      inv_next = (m_inv > 0) ? m_inv - 1 : 0;
      if (idx >= 1 && idx <= 4) begin
        if (level != m_prev) m_enemies = en_tab[idx];
        else if (enemy_kill && m_enemies > 0) m_enemies = m_enemies - 1;
        if (player_hit && m_inv == 0 && m_lives > 0) begin
          m_lives  = m_lives - 1;
          inv_next = INV_CYC;
        end
        if (key_pickup && idx == 3) m_key = 1;
      end
      m_inv = inv_next;
    end
    m_prev = level;
  endtask

  task automatic check_regs();
    check("lives_count", lives_count, m_lives);
    check("Lives", Lives, (m_lives != 0) ? 1 : 0);
    check("enemy_count", enemy_count, m_enemies);
    check("Keys", Keys, m_key);
    check("invuln", invuln, (m_inv != 0) ? 1 : 0);
  endtask

  // One clock: drive, check combinational Enemies mid-cycle, then check registered counts
  task automatic cycle(input logic [5:0] l, input logic hit, input logic kill, input logic key);
    level = l; player_hit = hit; enemy_kill = kill; key_pickup = key;
    @(negedge Clk);
    check("Enemies", Enemies, model_enemies_out());
    @(posedge Clk);
    model_step();
    #1;
    check_regs();
  endtask

  initial begin
    logic [5:0] rl;
    Reset = 1'b1; level = L_INI; player_hit = 0; enemy_kill = 0; key_pickup = 0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    check("rst_Lives", Lives, 1);
    check("rst_lives_count", lives_count, 3);
    check("rst_Enemies", Enemies, 0);
    check("rst_Keys", Keys, 0);
    check("rst_invuln", invuln, 0);

    repeat (3) cycle(L_INI, 1, 1, 1);
    check("ini_lives", lives_count, 3);

    // Entry into FIRST and kill countdown
    level = L_F1;
    #1 check("entry_Enemies", Enemies, 1);
    cycle(L_F1, 0, 0, 0);
    check("first_load", enemy_count, 3);
    for (int i = 0; i < 3; i++) cycle(L_F1, 0, 1, 0);
    check("kill_to_zero", enemy_count, 0);
    cycle(L_F1, 0, 1, 0);
    check("no_underflow", enemy_count, 0);
    check("Enemies_zero", Enemies, 0);

    // Hits with cooldown
    cycle(L_F1, 1, 0, 0);
    cycle(L_F1, 1, 0, 0);
    check("hit_once", lives_count, 2);
    for (int i = 0; i < 2; i++) cycle(L_F1, 0, 0, 0);
    check("invuln_held", invuln, 1);
    cycle(L_F1, 0, 0, 0);
    check("invuln_done", invuln, 0);
    cycle(L_F1, 1, 0, 0);
    check("hit_second", lives_count, 1);
    for (int i = 0; i < 4; i++) cycle(L_F1, 0, 0, 0);
    cycle(L_F1, 1, 0, 0);
    check("lives_zero", Lives, 0);
    for (int i = 0; i < 5; i++) cycle(L_F1, 1, 0, 0);
    check("lives_floor", lives_count, 0);
    cycle(L_INI, 0, 0, 0);
    check("ini_reload", lives_count, 3);

    // Key only counts in THIRD and survives until INI
    cycle(L_F2, 0, 0, 1);
    check("key_second", Keys, 0);
    cycle(L_F3, 0, 0, 0);
    cycle(L_F3, 0, 0, 1);
    check("key_third", Keys, 1);
    cycle(L_FN, 0, 0, 0);
    cycle(L_WIN, 0, 1, 0);
    check("key_win", Keys, 1);
    cycle(L_INI, 0, 0, 0);
    check("key_clr", Keys, 0);

    // Entry into SECOND with simultaneous kill and hit
    cycle(L_F1, 0, 0, 0);
    cycle(L_F2, 1, 1, 0);
    check("entry_kill_drop", enemy_count, 4);
    check("entry_hit", lives_count, 2);

    // Asynchronous reset mid-FIRST
    cycle(L_INI, 0, 0, 0);
    cycle(L_F1, 0, 0, 0);
    cycle(L_F1, 1, 1, 0);
    check("pre_rst_cnt", enemy_count, 2);
    check("pre_rst_inv", invuln, 1);
    #2 Reset = 1'b1;
    #1;
    check("arst_lives", lives_count, 3);
    check("arst_Lives", Lives, 1);
    check("arst_enemy", enemy_count, 0);
    check("arst_Keys", Keys, 0);
    check("arst_invuln", invuln, 0);
    @(posedge Clk);
    #1 Reset = 1'b0;
    model_reset();

    // Random traffic
    rl = L_INI;
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r >= 88) begin
        int k;
        k = $urandom_range(0, 9);
        if (k <= 5) rl = 6'b000001 << k;
        else if (k == 6) rl = 6'b000000;
        else if (k == 7) rl = 6'($urandom);
        else rl = 6'b000001 << $urandom_range(1, 4);
      end
      cycle(rl, ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 35),
            ($urandom_range(0, 99) < 20));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
